// File: rtl/mmc1_serial_loader.sv
// mmc1_serial_loader: oversampled MMC1 serial write port.
// Synchronises the CPU bus and detects writes to $8000-$FFFF. Runs the
// 5-bit shift / bit-7 reset sequence and issues one-clock load strobes
// to the bank register file.
// Optional: define MMC1_CONSEC_WRITE_FILTER_EN to drop a write that
// lands in the M2 cycle right after a committed write (D7=1 still honoured).
//
// state   | meaning
// IDLE    | waiting for a synced M2-high ROM write
// CAPTURE | M2 high, re-latching A14/A13/D0/D7 every clock
// COMMIT  | one clock, applies the latched write
// HOLDOFF | bus settle, M2 ignored for HOLDOFF_CYCLES clocks
module mmc1_serial_loader #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CPU_M2,
  input  logic       nCPU_ROMSEL,
  input  logic       nCPU_RW,
  input  logic       CPU_A13,
  input  logic       CPU_A14,
  input  logic       CPU_D0,
  input  logic       CPU_D7,
  output logic       REG_WE,
  output logic [1:0] REG_SEL,
  output logic [4:0] REG_DATA,
  output logic       CTRL_FORCE,
  output logic [2:0] SHIFT_CNT
);

  localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT, HOLDOFF} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] m2_sync, romsel_sync, rw_sync;
  logic              m2_s, romsel_s, rw_s, qualify;
  logic              a13_l, a14_l, d0_l, d7_l;
  logic [4:0]        shift;
  logic [HOLD_W-1:0] hold_cnt;
  logic              drop;

  assign m2_s     = m2_sync[SYNC_STAGES-1];
  assign romsel_s = romsel_sync[SYNC_STAGES-1];
  assign rw_s     = rw_sync[SYNC_STAGES-1];
  assign qualify  = m2_s & ~romsel_s & ~rw_s;

  // Bring the asynchronous bus strobes into the CLK domain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m2_sync     <= '0;
      romsel_sync <= '0;
      rw_sync     <= '0;
    end else begin
      m2_sync     <= {m2_sync[SYNC_STAGES-2:0], CPU_M2};
      romsel_sync <= {romsel_sync[SYNC_STAGES-2:0], nCPU_ROMSEL};
      rw_sync     <= {rw_sync[SYNC_STAGES-2:0], nCPU_RW};
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the M2 fall takes priority over ROMSEL rising with it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (qualify) state_next = CAPTURE;
      CAPTURE: begin
        if (!m2_s)                   state_next = COMMIT;
        else if (rw_s || romsel_s)   state_next = IDLE;
      end
      COMMIT:  state_next = HOLDOFF;
      HOLDOFF: if (hold_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raw address/data are sampled only while synced M2 is high; last sample wins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a13_l <= 1'b0;
      a14_l <= 1'b0;
      d0_l  <= 1'b0;
      d7_l  <= 1'b0;
    end else if ((state == IDLE && qualify) || (state == CAPTURE && m2_s)) begin
      a13_l <= CPU_A13;
      a14_l <= CPU_A14;
      d0_l  <= CPU_D0;
      d7_l  <= CPU_D7;
    end
  end

`ifdef MMC1_CONSEC_WRITE_FILTER_EN
  logic last_commit, discard;

  // Any M2-high phase seen without a write clears the back-to-back flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_commit <= 1'b0;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (qualify)   discard     <= last_commit;
          else if (m2_s) last_commit <= 1'b0;
        end
        CAPTURE: if (m2_s && (rw_s || romsel_s)) last_commit <= 1'b0;
        COMMIT:  last_commit <= 1'b1;
        default: ;
      endcase
    end
  end

  assign drop = discard & ~d7_l;
`else
  assign drop = 1'b0;
`endif

  // Commit actions, strobes and holdoff down-counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shift      <= 5'b10000;
      SHIFT_CNT  <= 3'd0;
      REG_WE     <= 1'b0;
      REG_SEL    <= 2'd0;
      REG_DATA   <= 5'd0;
      CTRL_FORCE <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      REG_WE     <= 1'b0;
      CTRL_FORCE <= 1'b0;
      if (state == COMMIT) begin
        hold_cnt <= HOLD_W'(HOLDOFF_CYCLES - 1);
        if (!drop) begin
          if (d7_l) begin
            shift      <= 5'b10000;
            SHIFT_CNT  <= 3'd0;
            CTRL_FORCE <= 1'b1;
          end else if (!shift[0]) begin
            shift     <= {d0_l, shift[4:1]};
            SHIFT_CNT <= SHIFT_CNT + 3'd1;
          end else begin
            REG_DATA  <= {d0_l, shift[4:1]};
            REG_SEL   <= {a14_l, a13_l};
            REG_WE    <= 1'b1;
            shift     <= 5'b10000;
            SHIFT_CNT <= 3'd0;
          end
        end
      end else if (state == HOLDOFF && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mmc1_serial_loader.sv
// Directed bench for mmc1_serial_loader: one task per scenario.
`timescale 1ns/1ps
module tb_mmc1_serial_loader;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CPU_M2 = 1'b0;
  logic       nCPU_ROMSEL = 1'b1;
  logic       nCPU_RW = 1'b1;
  logic       CPU_A13 = 1'b0;
  logic       CPU_A14 = 1'b0;
  logic       CPU_D0 = 1'b0;
  logic       CPU_D7 = 1'b0;
  logic       REG_WE;
  logic [1:0] REG_SEL;
  logic [4:0] REG_DATA;
  logic       CTRL_FORCE;
  logic [2:0] SHIFT_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  int we_pulses = 0;
  int force_pulses = 0;
  logic prev_we = 1'b0, prev_force = 1'b0;
  bit overlap_seen = 1'b0, wide_seen = 1'b0;

  mmc1_serial_loader dut (
    .CLK(CLK), .RST(RST), .CPU_M2(CPU_M2), .nCPU_ROMSEL(nCPU_ROMSEL),
    .nCPU_RW(nCPU_RW), .CPU_A13(CPU_A13), .CPU_A14(CPU_A14),
    .CPU_D0(CPU_D0), .CPU_D7(CPU_D7), .REG_WE(REG_WE), .REG_SEL(REG_SEL),
    .REG_DATA(REG_DATA), .CTRL_FORCE(CTRL_FORCE), .SHIFT_CNT(SHIFT_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (REG_WE) we_pulses++;
    if (CTRL_FORCE) force_pulses++;
    if (REG_WE && CTRL_FORCE) overlap_seen = 1'b1;
    if ((REG_WE && prev_we) || (CTRL_FORCE && prev_force)) wide_seen = 1'b1;
    prev_we = REG_WE;
    prev_force = CTRL_FORCE;
  end

  // One M2 period: 8 clocks high, 8 low. abort_rw / abort_rs give the
  // high-phase clock at which RW or ROMSEL rises early (-1 = never).
  task automatic bus_cycle(input logic wr, input logic rom, input logic a14,
                           input logic a13, input logic d0, input logic d7,
                           input int abort_rw, input int abort_rs);
    @(negedge CLK);
    CPU_M2 = 1'b1; nCPU_ROMSEL = ~rom; nCPU_RW = ~wr;
    CPU_A14 = a14; CPU_A13 = a13; CPU_D0 = d0; CPU_D7 = d7;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == abort_rw) nCPU_RW = 1'b1;
      if (i == abort_rs) nCPU_ROMSEL = 1'b1;
    end
    CPU_M2 = 1'b0; nCPU_ROMSEL = 1'b1;
    repeat (8) @(negedge CLK);
    nCPU_RW = 1'b1; CPU_D7 = 1'b0;
  endtask

  // A ROM write followed by a read cycle, so writes are never adjacent.
  task automatic wr(input logic a14, input logic a13, input logic d0, input logic d7);
    bus_cycle(1'b1, 1'b1, a14, a13, d0, d7, -1, -1);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (REG_WE !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", REG_WE); end
    n_cmp++; if (CTRL_FORCE !== 1'b0) begin n_bad++; $display("FAIL rst_force got %b want 0", CTRL_FORCE); end
    @(negedge CLK); RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (REG_SEL !== 2'd0) begin n_bad++; $display("FAIL rst_sel got %0d want 0", REG_SEL); end
    n_cmp++; if (REG_DATA !== 5'd0) begin n_bad++; $display("FAIL rst_data got %b want 00000", REG_DATA); end
    n_cmp++; if (SHIFT_CNT !== 3'd0) begin n_bad++; $display("FAIL rst_cnt got %0d want 0", SHIFT_CNT); end
  endtask

  task automatic test_prg_load;
    logic [4:0] bits;
    int we0;
    bits = 5'b10110;
    we0 = we_pulses;
    for (int i = 0; i < 4; i++) begin
      wr(1'b1, 1'b1, bits[i], 1'b0);
      n_cmp++; if (SHIFT_CNT !== 3'(i + 1)) begin n_bad++; $display("FAIL prg_cnt%0d got %0d want %0d", i, SHIFT_CNT, i + 1); end
    end
    n_cmp++; if (we_pulses !== we0) begin n_bad++; $display("FAIL prg_partial_we got %0d want %0d", we_pulses, we0); end
    wr(1'b1, 1'b1, bits[4], 1'b0);
    n_cmp++; if (we_pulses !== we0 + 1) begin n_bad++; $display("FAIL prg_we got %0d want %0d", we_pulses, we0 + 1); end
    n_cmp++; if (REG_SEL !== 2'd3) begin n_bad++; $display("FAIL prg_sel got %0d want 3", REG_SEL); end
    n_cmp++; if (REG_DATA !== 5'b10110) begin n_bad++; $display("FAIL prg_data got %b want 10110", REG_DATA); end
    n_cmp++; if (SHIFT_CNT !== 3'd0) begin n_bad++; $display("FAIL prg_cnt_end got %0d want 0", SHIFT_CNT); end
  endtask

  task automatic test_ctrl_reset;
    int we0, f0;
    we0 = we_pulses; f0 = force_pulses;
    repeat (3) wr(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (SHIFT_CNT !== 3'd3) begin n_bad++; $display("FAIL d7_pre_cnt got %0d want 3", SHIFT_CNT); end
    wr(1'b0, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (SHIFT_CNT !== 3'd0) begin n_bad++; $display("FAIL d7_cnt got %0d want 0", SHIFT_CNT); end
    n_cmp++; if (force_pulses !== f0 + 1) begin n_bad++; $display("FAIL d7_force got %0d want %0d", force_pulses, f0 + 1); end
    n_cmp++; if (we_pulses !== we0) begin n_bad++; $display("FAIL d7_we got %0d want %0d", we_pulses, we0); end
    repeat (5) wr(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (we_pulses !== we0 + 1) begin n_bad++; $display("FAIL ctl_we got %0d want %0d", we_pulses, we0 + 1); end
    n_cmp++; if (REG_SEL !== 2'd0) begin n_bad++; $display("FAIL ctl_sel got %0d want 0", REG_SEL); end
    n_cmp++; if (REG_DATA !== 5'b11111) begin n_bad++; $display("FAIL ctl_data got %b want 11111", REG_DATA); end
    n_cmp++; if (force_pulses !== f0 + 1) begin n_bad++; $display("FAIL ctl_force got %0d want %0d", force_pulses, f0 + 1); end
  endtask

  task automatic test_ignored;
    int we0, f0;
    we0 = we_pulses; f0 = force_pulses;
    wr(1'b1, 1'b0, 1'b1, 1'b0);
    wr(1'b1, 1'b0, 1'b0, 1'b0);
    bus_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    bus_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
    bus_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    n_cmp++; if (SHIFT_CNT !== 3'd2) begin n_bad++; $display("FAIL ign_cnt got %0d want 2", SHIFT_CNT); end
    n_cmp++; if (we_pulses !== we0 || force_pulses !== f0) begin n_bad++; $display("FAIL ign_strobes got we %0d force %0d want %0d %0d", we_pulses, force_pulses, we0, f0); end
    wr(1'b1, 1'b0, 1'b0, 1'b0);
    wr(1'b1, 1'b0, 1'b1, 1'b0);
    wr(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (we_pulses !== we0 + 1) begin n_bad++; $display("FAIL ign_we got %0d want %0d", we_pulses, we0 + 1); end
    n_cmp++; if (REG_SEL !== 2'd2) begin n_bad++; $display("FAIL ign_sel got %0d want 2", REG_SEL); end
    n_cmp++; if (REG_DATA !== 5'b11001) begin n_bad++; $display("FAIL ign_data got %b want 11001", REG_DATA); end
  endtask

  task automatic test_abort;
    int we0, f0;
    we0 = we_pulses; f0 = force_pulses;
    wr(1'b1, 1'b1, 1'b1, 1'b0);
    bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3, -1);
    n_cmp++; if (SHIFT_CNT !== 3'd1) begin n_bad++; $display("FAIL abort_rw_cnt got %0d want 1", SHIFT_CNT); end
    bus_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 3);
    n_cmp++; if (SHIFT_CNT !== 3'd1) begin n_bad++; $display("FAIL abort_rs_cnt got %0d want 1", SHIFT_CNT); end
    n_cmp++; if (we_pulses !== we0 || force_pulses !== f0) begin n_bad++; $display("FAIL abort_strobes got we %0d force %0d want %0d %0d", we_pulses, force_pulses, we0, f0); end
  endtask

  task automatic test_async_reset;
    int we0;
    wr(1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (SHIFT_CNT !== 3'd2) begin n_bad++; $display("FAIL ar_pre_cnt got %0d want 2", SHIFT_CNT); end
    #3 RST = 1'b1;
    #1;
    n_cmp++; if (SHIFT_CNT !== 3'd0) begin n_bad++; $display("FAIL ar_cnt got %0d want 0", SHIFT_CNT); end
    n_cmp++; if (REG_DATA !== 5'd0) begin n_bad++; $display("FAIL ar_data got %b want 00000", REG_DATA); end
    n_cmp++; if (REG_SEL !== 2'd0) begin n_bad++; $display("FAIL ar_sel got %0d want 0", REG_SEL); end
    @(negedge CLK); RST = 1'b0;
    we0 = we_pulses;
    repeat (4) wr(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (we_pulses !== we0) begin n_bad++; $display("FAIL ar_four_we got %0d want %0d", we_pulses, we0); end
    n_cmp++; if (SHIFT_CNT !== 3'd4) begin n_bad++; $display("FAIL ar_four_cnt got %0d want 4", SHIFT_CNT); end
    wr(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (we_pulses !== we0 + 1) begin n_bad++; $display("FAIL ar_fifth_we got %0d want %0d", we_pulses, we0 + 1); end
    n_cmp++; if (REG_DATA !== 5'b01111) begin n_bad++; $display("FAIL ar_data2 got %b want 01111", REG_DATA); end
  endtask

  task automatic test_back_to_back;
    int f0;
    logic [2:0] exp_cnt;
`ifdef MMC1_CONSEC_WRITE_FILTER_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    f0 = force_pulses;
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (SHIFT_CNT !== exp_cnt) begin n_bad++; $display("FAIL b2b_cnt got %0d want %0d", SHIFT_CNT, exp_cnt); end
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    n_cmp++; if (SHIFT_CNT !== exp_cnt + 3'd1) begin n_bad++; $display("FAIL b2b_pre_d7 got %0d want %0d", SHIFT_CNT, exp_cnt + 3'd1); end
    bus_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
    bus_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    n_cmp++; if (SHIFT_CNT !== 3'd0) begin n_bad++; $display("FAIL b2b_d7_cnt got %0d want 0", SHIFT_CNT); end
    n_cmp++; if (force_pulses !== f0 + 1) begin n_bad++; $display("FAIL b2b_d7_force got %0d want %0d", force_pulses, f0 + 1); end
  endtask

  task automatic test_strobe_shape;
    n_cmp++; if (overlap_seen !== 1'b0) begin n_bad++; $display("FAIL strobe_overlap got %b want 0", overlap_seen); end
    n_cmp++; if (wide_seen !== 1'b0) begin n_bad++; $display("FAIL strobe_width got %b want 0", wide_seen); end
  endtask

  initial begin
    test_reset;
    test_prg_load;
    test_ctrl_reset;
    test_ignored;
    test_abort;
    test_async_reset;
    test_back_to_back;
    test_strobe_shape;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmc1_serial_loader.md
Name: mmc1_serial_loader

Overview:
- Synchronous replacement for the MMC1 serial write port. It oversamples the asynchronous CPU bus on a fast board clock and detects CPU writes to $8000-$FFFF.
- It runs the 5-bit serial shift sequence and the bit-7 reset, then issues one-clock write strobes to the mapper's control/CHR0/CHR1/PRG register file.
- It sits between the cartridge edge pins and the bank-register/address-mux logic, and owns all sequencing of register loads.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth on CPU_M2, nCPU_ROMSEL, nCPU_RW (min 2).
- HOLDOFF_CYCLES, 4, CLK cycles after a commit during which a new M2 fall is ignored (bus settle, min 1).

Ports:
- CLK  in  1  board clock, >=8x CPU_M2 frequency.
- RST  in  1  asynchronous active-high reset.
- CPU_M2  in  1  CPU phi2, asynchronous.
- nCPU_ROMSEL  in  1  low = A15 high and M2 high, asynchronous.
- nCPU_RW  in  1  low = CPU write.
- CPU_A13  in  1  register select bit 0.
- CPU_A14  in  1  register select bit 1.
- CPU_D0  in  1  serial data bit.
- CPU_D7  in  1  shift-register reset bit.
- REG_WE  out  1  one-CLK strobe: write REG_DATA to register REG_SEL.
- REG_SEL  out  2  0 control, 1 CHR bank 0, 2 CHR bank 1, 3 PRG bank.
- REG_DATA  out  5  assembled value, first-written bit in [0].
- CTRL_FORCE  out  1  one-CLK strobe: register file ORs control with 5'b01100.
- SHIFT_CNT  out  3  bits accepted in the current sequence, 0..4.

Behaviour:
- Reset: RST is asynchronous and active-high. All outputs are 0, the shift register is 5'b10000, state is IDLE, and synchronizers are cleared. Deasserting RST mid-sequence starts a fresh sequence.
- Sync: M2, ROMSEL and RW each pass through SYNC_STAGES flops. A13, A14, D0 and D7 are sampled raw, but only while synchronized M2 is high and stable.
- States:
  - IDLE: waits for synced M2=1, ROMSEL=0, RW=0, then goes to CAPTURE.
  - CAPTURE: every CLK while M2 stays high, re-latches A14, A13, D0 and D7; the last sample before the fall wins.
  - If RW rises or ROMSEL rises while M2 is still high, the cycle is aborted and the block returns to IDLE with no side effects.
  - Synced M2 falling edge moves the block to COMMIT.
  - COMMIT: lasts exactly one CLK, then goes to HOLDOFF.
  - HOLDOFF: a counter runs HOLDOFF_CYCLES, then the block returns to IDLE. M2 activity is ignored during HOLDOFF.
- COMMIT actions:
  - D7=1: shift register becomes 10000, SHIFT_CNT becomes 0, CTRL_FORCE pulses, REG_WE stays 0.
  - D7=0 and shift[0]=0: shift becomes {D0, shift[4:1]} and SHIFT_CNT increments.
  - D7=0 and shift[0]=1 (fifth bit): REG_DATA becomes {D0, shift[4:1]} and REG_SEL becomes {A14, A13]. REG_WE pulses. Shift becomes 10000 and SHIFT_CNT becomes 0.
- Latency: a strobe is asserted on the CLK edge that exits COMMIT, i.e. SYNC_STAGES+2 CLK after the raw M2 fall.
- REG_DATA and REG_SEL hold their value until the next fifth-bit commit.
- Strobes are mutually exclusive and never last longer than one CLK.
- Reads (RW=1) and accesses below $8000 (ROMSEL high) never change state.

Optional Feature:
- Macro: MMC1_CONSEC_WRITE_FILTER_EN.
- Defined:
  - The block records whether the previous M2 cycle committed a write.
  - A write whose M2 high phase starts within one M2 period of the prior commit is discarded. This means no M2 low/high pass through IDLE without a write.
  - This emulates MMC1 rejection of back-to-back writes, as seen with RMW instructions.
  - A D7=1 write is never discarded.
- Undefined: every qualifying write commits.

Test Plan:
- Write D0 = 0,1,1,0,1 to $E000 on separate M2 cycles -> one REG_WE, REG_SEL=3, REG_DATA=5'b10110, SHIFT_CNT returns to 0.
- Three bits written to $A000, then D7=1 write, then five bits of 1 to $8000 -> one CTRL_FORCE pulse, then REG_WE with REG_SEL=0, REG_DATA=5'b11111. No strobe occurs for the partial sequence.
- CPU read cycles and $6000 writes interleaved inside a sequence -> SHIFT_CNT unchanged, no strobes.
- RST asserted asynchronously after 2 bits -> outputs 0 immediately. Four following writes give no REG_WE; the fifth gives REG_WE.
- RW rises mid-M2-high -> abort, SHIFT_CNT unchanged.
- With MMC1_CONSEC_WRITE_FILTER_EN: two adjacent-cycle writes with D0=1,0 -> only the first is accepted (SHIFT_CNT +1). A D7=1 write in the adjacent cycle is still honoured. Without the macro: SHIFT_CNT +2.
